prng_xoshiro256p_jump: RTL and testbench

//  Jump/long-jump engine for prngXoshiro256p; drives its seed interface, i_cg and reads o_s0..o_s3.
//  On request, computes jump() or long_jump() by stepping the generator 256 times.
//  It accumulates the selected states, then loads the accumulator back as the new seed.
//  It is the sole driver of the generator's i_cg/i_seed*.

---
 rtl/prng_xoshiro256p_jump.sv | 166 ++++++++++++++++
 tb/tb_prng_xoshiro256p_jump.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_xoshiro256p_jump.sv
// Jump / long-jump engine for a xoshiro256+ generator: steps the generator 256 times,
// folds the selected states into an accumulator, then reloads it as the new seed.
module prng_xoshiro256p_jump #(
    parameter logic [63:0] JUMP_K0     = 64'h180ec6d33cfd0aba,
    parameter logic [63:0] JUMP_K1     = 64'hd5a61266f0c9392c,
    parameter logic [63:0] JUMP_K2     = 64'ha9582618e03fc9aa,
    parameter logic [63:0] JUMP_K3     = 64'h39abdc4529b1661c,
    parameter logic [63:0] LONGJUMP_K0 = 64'h76e15d3efefdcbbf,
    parameter logic [63:0] LONGJUMP_K1 = 64'hc5004e441c522fb3,
    parameter logic [63:0] LONGJUMP_K2 = 64'h77710069854ee241,
    parameter logic [63:0] LONGJUMP_K3 = 64'h39109bb02acbe635
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_jumpReq,
    input  logic        i_longJump,
    input  logic        i_userCg,
    input  logic        i_userSeedValid,
    input  logic [63:0] i_userSeedS0,
    input  logic [63:0] i_userSeedS1,
    input  logic [63:0] i_userSeedS2,
    input  logic [63:0] i_userSeedS3,
    input  logic [63:0] i_s0,
    input  logic [63:0] i_s1,
    input  logic [63:0] i_s2,
    input  logic [63:0] i_s3,
    output logic        o_prngCg,
    output logic        o_seedValid,
    output logic [63:0] o_seedS0,
    output logic [63:0] o_seedS1,
    output logic [63:0] o_seedS2,
    output logic [63:0] o_seedS3,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    logic [1:0]  state_r;
    logic [7:0]  cnt_r;
    logic        sel_r;
    logic        done_r;
    logic [63:0] acc0_r;
    logic [63:0] acc1_r;
    logic [63:0] acc2_r;
    logic [63:0] acc3_r;
    logic [63:0] kword_s;
    logic        kbit_s;

    // Polynomial word for the current step: sel picks the table, cnt[7:6] the word
    always_comb begin
        kword_s = 64'd0;
        case ({sel_r, cnt_r[7:6]})
            3'b000:  kword_s = JUMP_K0;
            3'b001:  kword_s = JUMP_K1;
            3'b010:  kword_s = JUMP_K2;
            3'b011:  kword_s = JUMP_K3;
            3'b100:  kword_s = LONGJUMP_K0;
            3'b101:  kword_s = LONGJUMP_K1;
            3'b110:  kword_s = LONGJUMP_K2;
            3'b111:  kword_s = LONGJUMP_K3;
            default: kword_s = 64'd0;
        endcase
    end

    // Bits are consumed LSB first within each word
    assign kbit_s = kword_s[cnt_r[5:0]];

    // Sequencer, step counter and XOR accumulator
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            sel_r   <= 1'b0;
            done_r  <= 1'b0;
            acc0_r  <= 64'd0;
            acc1_r  <= 64'd0;
            acc2_r  <= 64'd0;
            acc3_r  <= 64'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_jumpReq) begin
                        state_r <= ST_RUN;
                        sel_r   <= i_longJump;
                        cnt_r   <= 8'd0;
                        acc0_r  <= 64'd0;
                        acc1_r  <= 64'd0;
                        acc2_r  <= 64'd0;
                        acc3_r  <= 64'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (kbit_s) begin
                        acc0_r <= acc0_r ^ i_s0;
                        acc1_r <= acc1_r ^ i_s1;
                        acc2_r <= acc2_r ^ i_s2;
                        acc3_r <= acc3_r ^ i_s3;
                    end else begin
                        acc0_r <= acc0_r;
                        acc1_r <= acc1_r;
                        acc2_r <= acc2_r;
                        acc3_r <= acc3_r;
                    end
                    if (cnt_r == 8'd255) begin
                        state_r <= ST_LOAD;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Generator control: user passthrough when idle, forced stepping/loading otherwise
    always_comb begin
        o_prngCg    = i_userCg;
        o_seedValid = i_userSeedValid;
        o_seedS0    = i_userSeedS0;
        o_seedS1    = i_userSeedS1;
        o_seedS2    = i_userSeedS2;
        o_seedS3    = i_userSeedS3;
        case (state_r)
            ST_IDLE: begin
                o_prngCg    = i_userCg;
                o_seedValid = i_userSeedValid;
            end
            ST_RUN: begin
                o_prngCg    = 1'b1;
                o_seedValid = 1'b0;
                o_seedS0    = acc0_r;
                o_seedS1    = acc1_r;
                o_seedS2    = acc2_r;
                o_seedS3    = acc3_r;
            end
            ST_LOAD: begin
                o_prngCg    = 1'b1;
                o_seedValid = 1'b1;
                o_seedS0    = acc0_r;
                o_seedS1    = acc1_r;
                o_seedS2    = acc2_r;
                o_seedS3    = acc3_r;
            end
            default: begin
                o_prngCg    = i_userCg;
                o_seedValid = i_userSeedValid;
            end
        endcase
    end

    assign o_busy = (state_r == ST_RUN) || (state_r == ST_LOAD);
    assign o_done = done_r;

endmodule

// File: tb/tb_prng_xoshiro256p_jump.sv
// Bench for prng_xoshiro256p_jump: a xoshiro256+ state model acts as the generator,
// and results are compared against a direct software-style jump()/long_jump() model.
module tb_prng_xoshiro256p_jump;

    typedef logic [3:0][63:0] st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_req = 1'b0;
    logic        long_jump = 1'b0;
    logic        user_cg = 1'b0;
    logic        user_sv = 1'b0;
    st_t         user_seed = '0;
    st_t         gs;
    logic        o_prngCg, o_seedValid, o_busy, o_done;
    logic [63:0] o_s0, o_s1, o_s2, o_s3;

    int checks = 0;
    int failures = 0;

    // results captured by run_jump
    int   busy_cycles, load_cycles, done_cycle, sv_any, busy_after_rst;
    st_t  load_word, done_state;

    prng_xoshiro256p_jump dut (
        .i_clk(clk), .i_rst(rst), .i_jumpReq(jump_req), .i_longJump(long_jump),
        .i_userCg(user_cg), .i_userSeedValid(user_sv),
        .i_userSeedS0(user_seed[0]), .i_userSeedS1(user_seed[1]),
        .i_userSeedS2(user_seed[2]), .i_userSeedS3(user_seed[3]),
        .i_s0(gs[0]), .i_s1(gs[1]), .i_s2(gs[2]), .i_s3(gs[3]),
        .o_prngCg(o_prngCg), .o_seedValid(o_seedValid),
        .o_seedS0(o_s0), .o_seedS1(o_s1), .o_seedS2(o_s2), .o_seedS3(o_s3),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    function automatic st_t xnext(input st_t s);
        st_t r;
        logic [63:0] t;
        r = s;
        t = s[1] << 17;
        r[2] = r[2] ^ r[0];
        r[3] = r[3] ^ r[1];
        r[1] = r[1] ^ r[2];
        r[0] = r[0] ^ r[3];
        r[2] = r[2] ^ t;
        r[3] = (r[3] << 45) | (r[3] >> 19);
        return r;
    endfunction

    function automatic st_t jump_ref(input st_t s, input bit lj);
        st_t k, acc, cur;
        if (lj) k = {64'h39109bb02acbe635, 64'h77710069854ee241, 64'hc5004e441c522fb3, 64'h76e15d3efefdcbbf};
        else    k = {64'h39abdc4529b1661c, 64'ha9582618e03fc9aa, 64'hd5a61266f0c9392c, 64'h180ec6d33cfd0aba};
        acc = '0;
        cur = s;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 64; b++) begin
                if (k[w][b]) acc = acc ^ cur;
                cur = xnext(cur);
            end
        end
        return acc;
    endfunction

    // External generator: seed load wins, otherwise step when enabled
    always_ff @(posedge clk) begin
        if (o_seedValid) gs <= {o_s3, o_s2, o_s1, o_s0};
        else if (o_prngCg) gs <= xnext(gs);
    end

    function automatic st_t rnd_state();
        st_t r;
        for (int i = 0; i < 4; i++) r[i] = {$urandom(), $urandom()};
        return r;
    endfunction

    task automatic seed_gen(input st_t s);
        @(negedge clk);
        user_sv = 1'b1;
        user_seed = s;
        @(negedge clk);
        user_sv = 1'b0;
    endtask

    // Drives one jump; poke_at/rst_at are step indices (-1 = none)
    task automatic run_jump(input bit lj, input int poke_at, input int rst_at,
                            input bit started, input bit chain, input bit next_lj);
        int cyc;
        bit fin;
        if (!started) begin
            @(negedge clk);
            jump_req = 1'b1;
            long_jump = lj;
        end
        cyc = 1;
        fin = 1'b0;
        busy_cycles = 0; load_cycles = 0; done_cycle = 0; sv_any = 0; busy_after_rst = 0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            jump_req = 1'b0; user_sv = 1'b0; user_cg = 1'b0;
            rst = (cyc - 2 == rst_at);
            if (cyc - 2 == poke_at) begin
                jump_req = 1'b1; long_jump = ~lj; user_cg = 1'b1; user_sv = 1'b1;
                user_seed = rnd_state();
            end
            #1;
            if (o_busy) busy_cycles++;
            if (o_seedValid) sv_any++;
            if (o_seedValid && o_busy) begin
                load_cycles++;
                load_word = {o_s3, o_s2, o_s1, o_s0};
            end
            if (rst_at >= 0 && cyc == rst_at + 3) busy_after_rst = o_busy;
            if (o_done) begin
                done_cycle = cyc;
                done_state = gs;
                fin = 1'b1;
                if (chain) begin
                    jump_req = 1'b1;
                    long_jump = next_lj;
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b done=%b, required 0 0", o_busy, o_done);
        end
        user_cg = 1'b1; user_sv = 1'b1; user_seed = rnd_state();
        #1;
        checks++;
        if ({o_prngCg, o_seedValid, o_s3, o_s2, o_s1, o_s0} !== {2'b11, user_seed}) begin
            failures++;
            $display("FAIL reset_passthrough: got %b%b %h, required 11 %h",
                     o_prngCg, o_seedValid, {o_s3, o_s2, o_s1, o_s0}, user_seed);
        end
        rst = 1'b0; user_cg = 1'b0; user_sv = 1'b0;
    endtask

    task automatic test_passthrough();
        st_t s;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            user_cg = 1'($urandom());
            user_sv = 1'($urandom());
            user_seed = (i == 0) ? st_t'({64'd4, 64'd3, 64'd2, 64'd1}) : rnd_state();
            if (i == 0) user_sv = 1'b1;
            #1;
            checks++;
            if ({o_prngCg, o_seedValid, o_s3, o_s2, o_s1, o_s0} !== {user_cg, user_sv, user_seed}) begin
                failures++;
                $display("FAIL passthrough[%0d]: got %b%b %h, required %b%b %h", i,
                         o_prngCg, o_seedValid, {o_s3, o_s2, o_s1, o_s0}, user_cg, user_sv, user_seed);
            end
        end
        s = rnd_state();
        seed_gen(s);
        checks++;
        if (gs !== s) begin
            failures++;
            $display("FAIL seed_load: state %h, required %h", gs, s);
        end
    endtask

    task automatic test_model_sanity();
        st_t s, d;
        s = {64'd4, 64'd3, 64'd2, 64'd1};
        d = s ^ xnext(s);
        checks++;
        if (d !== st_t'({64'h0000C00000000004, 64'h0000000000040001, 64'd2, 64'd6})) begin
            failures++;
            $display("FAIL model_step: got %h, required 0000c00000000004 40001 2 6", d);
        end
    endtask

    task automatic test_jump(input st_t s, input bit lj, input string nm);
        st_t exp;
        exp = jump_ref(s, lj);
        seed_gen(s);
        run_jump(lj, -1, -1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done_cycle != 259 || busy_cycles != 257) begin
            failures++;
            $display("FAIL %s_timing: done at edge %0d busy %0d, required 258 and 257",
                     nm, done_cycle - 1, busy_cycles);
        end
        checks++;
        if (load_cycles != 1 || load_word !== exp) begin
            failures++;
            $display("FAIL %s_load: pulses %0d word %h, required 1 %h", nm, load_cycles, load_word, exp);
        end
        checks++;
        if (done_state !== exp) begin
            failures++;
            $display("FAIL %s_state: got %h, required %h", nm, done_state, exp);
        end
    endtask

    task automatic test_ignore_busy();
        st_t s, exp;
        s = {64'd4, 64'd3, 64'd2, 64'd1};
        exp = jump_ref(s, 1'b0);
        seed_gen(s);
        run_jump(1'b0, 100, -1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done_state !== exp || load_cycles != 1 || done_cycle != 259) begin
            failures++;
            $display("FAIL ignore_busy: state %h loads %0d done %0d, required %h 1 259",
                     done_state, load_cycles, done_cycle, exp);
        end
    endtask

    task automatic test_seed_with_req();
        st_t s, exp;
        s = rnd_state();
        exp = jump_ref(s, 1'b1);
        @(negedge clk);
        user_sv = 1'b1; user_seed = s; jump_req = 1'b1; long_jump = 1'b1;
        run_jump(1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (done_state !== exp) begin
            failures++;
            $display("FAIL seed_with_req: got %h, required %h", done_state, exp);
        end
    endtask

    task automatic test_back_to_back();
        st_t s, j1, j2;
        s = rnd_state();
        j1 = jump_ref(s, 1'b0);
        j2 = jump_ref(j1, 1'b1);
        seed_gen(s);
        run_jump(1'b0, -1, -1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (done_state !== j1) begin
            failures++;
            $display("FAIL b2b_first: got %h, required %h", done_state, j1);
        end
        run_jump(1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (done_state !== j2 || done_cycle != 259) begin
            failures++;
            $display("FAIL b2b_second: got %h done %0d, required %h 259", done_state, done_cycle, j2);
        end
    endtask

    task automatic test_reset_mid();
        seed_gen(rnd_state());
        run_jump(1'b0, -1, 50, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy_after_rst !== 0 || sv_any != 0 || done_cycle != 0) begin
            failures++;
            $display("FAIL reset_mid: busy_next %0d seed_pulses %0d done_cycle %0d, required 0 0 0",
                     busy_after_rst, sv_any, done_cycle);
        end
        @(negedge clk);
        user_cg = 1'b1; user_sv = 1'b1; user_seed = rnd_state();
        #1;
        checks++;
        if ({o_prngCg, o_seedValid, o_s3, o_s2, o_s1, o_s0} !== {2'b11, user_seed}) begin
            failures++;
            $display("FAIL reset_mid_passthrough: got %b%b %h, required 11 %h",
                     o_prngCg, o_seedValid, {o_s3, o_s2, o_s1, o_s0}, user_seed);
        end
        user_cg = 1'b0; user_sv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_model_sanity();
        test_jump({64'd4, 64'd3, 64'd2, 64'd1}, 1'b0, "jump_1234");
        test_jump({64'd4, 64'd3, 64'd2, 64'd1}, 1'b1, "long_1234");
        test_jump(rnd_state(), 1'b0, "jump_rand");
        test_jump(rnd_state(), 1'b1, "long_rand");
        test_ignore_busy();
        test_seed_with_req();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
